// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: two-master Wishbone-pipelined arbiter in front of a
// single-port block RAM slave.
//   m0 (hart data port) and m1 (loader/debug/DMA) request with cyc; one owner
//   at a time is granted. Slave-side signals are a combinational mux of the
//   owner, acks are routed back to the owner using an outstanding-beat count,
//   and a burst counter forces the owner off the bus after MAX_BURST beats
//   when the other master is waiting.
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_m{0,1}_{cyc,stb,we,sel,addr,data}  master requests
//   o_m{0,1}_{data,stall,ack}            master responses
//   o_s_{cyc,stb,we,sel,addr,data}       slave request
//   i_s_{data,stall,ack}                 slave response
//   o_grant         one-hot owner (00 = idle), registered
//   o_protocol_err  sticky flag for acks with nothing outstanding
module wb_bram_arbiter #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_BURST       = 8,
  parameter bit          FIXED_PRIO      = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  input  logic                i_m0_we,
  input  logic [XLEN/8-1:0]   i_m0_sel,
  input  logic [XLEN-1:0]     i_m0_addr,
  input  logic [XLEN-1:0]     i_m0_data,
  output logic [XLEN-1:0]     o_m0_data,
  output logic                o_m0_stall,
  output logic                o_m0_ack,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  input  logic                i_m1_we,
  input  logic [XLEN/8-1:0]   i_m1_sel,
  input  logic [XLEN-1:0]     i_m1_addr,
  input  logic [XLEN-1:0]     i_m1_data,
  output logic [XLEN-1:0]     o_m1_data,
  output logic                o_m1_stall,
  output logic                o_m1_ack,
  output logic                o_s_cyc,
  output logic                o_s_stb,
  output logic                o_s_we,
  output logic [XLEN/8-1:0]   o_s_sel,
  output logic [XLEN-1:0]     o_s_addr,
  output logic [XLEN-1:0]     o_s_data,
  input  logic [XLEN-1:0]     i_s_data,
  input  logic                i_s_stall,
  input  logic                i_s_ack,
  output logic [1:0]          o_grant,
  output logic                o_protocol_err
);

  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state, state_nx, rel_state;
  logic [1:0]     grant_nx, rel_grant;
  logic [OCW-1:0] outstanding, outstanding_nx;
  logic [BCW-1:0] beats, beats_nx;
  logic           last_owner, last_owner_nx;
  logic           err_nx;

  logic owner, owner_cyc, owner_stb, other_cyc, owning;
  logic fairness_hold, gate, ack_ok, accept, pick;

  // Slave/master muxing, counters and next-state.
  always_comb begin
    o_s_cyc        = 1'b0;
    o_s_stb        = 1'b0;
    o_s_we         = 1'b0;
    o_s_sel        = '0;
    o_s_addr       = '0;
    o_s_data       = '0;
    o_m0_data      = '0;
    o_m1_data      = '0;
    o_m0_stall     = 1'b1;
    o_m1_stall     = 1'b1;
    o_m0_ack       = 1'b0;
    o_m1_ack       = 1'b0;
    state_nx       = state;
    grant_nx       = o_grant;
    last_owner_nx  = last_owner;
    outstanding_nx = outstanding;
    beats_nx       = beats;
    pick           = 1'b0;

    // owner index is meaningful in OWN0/OWN1/DRAIN; grant encodes it
    owner         = o_grant[1];
    owner_cyc     = owner ? i_m1_cyc : i_m0_cyc;
    owner_stb     = owner ? i_m1_stb : i_m0_stb;
    other_cyc     = owner ? i_m0_cyc : i_m1_cyc;
    owning        = (state == OWN0) || (state == OWN1);
    fairness_hold = owning && (beats == BCW'(MAX_BURST)) && other_cyc;
    gate          = (outstanding == OCW'(MAX_OUTSTANDING)) || fairness_hold;
    // acks with nothing outstanding (or while idle) are dropped and flagged
    ack_ok        = i_s_ack && (state != IDLE) && (outstanding != '0);
    err_nx        = o_protocol_err || (i_s_ack && !ack_ok);

    if (owning) begin
      o_s_cyc  = owner_cyc || (outstanding != '0);
      o_s_stb  = owner_stb && owner_cyc && !gate;
      o_s_we   = owner ? i_m1_we   : i_m0_we;
      o_s_sel  = owner ? i_m1_sel  : i_m0_sel;
      o_s_addr = owner ? i_m1_addr : i_m0_addr;
      o_s_data = owner ? i_m1_data : i_m0_data;
      if (owner) o_m1_stall = i_s_stall || gate;
      else       o_m0_stall = i_s_stall || gate;
    end else if (state == DRAIN) begin
      o_s_cyc = (outstanding != '0);
    end

    // response routing continues through DRAIN
    if (state != IDLE) begin
      if (owner) begin
        o_m1_ack  = ack_ok;
        o_m1_data = i_s_data;
      end else begin
        o_m0_ack  = ack_ok;
        o_m0_data = i_s_data;
      end
    end

    accept = o_s_stb && !i_s_stall;
    case ({accept, ack_ok})
      2'b10:   outstanding_nx = outstanding + OCW'(1);
      2'b01:   outstanding_nx = outstanding - OCW'(1);
      default: outstanding_nx = outstanding;
    endcase

    // hand the bus straight to a waiting master, no idle bubble
    rel_state = other_cyc ? (owner ? OWN0 : OWN1) : IDLE;
    rel_grant = other_cyc ? (owner ? 2'b01 : 2'b10) : 2'b00;

    case (state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          pick = FIXED_PRIO ? 1'b0 : !last_owner;
          state_nx = pick ? OWN1 : OWN0;
          grant_nx = pick ? 2'b10 : 2'b01;
        end else if (i_m0_cyc) begin
          state_nx = OWN0;
          grant_nx = 2'b01;
        end else if (i_m1_cyc) begin
          state_nx = OWN1;
          grant_nx = 2'b10;
        end
      end
      OWN0, OWN1: begin
        if (!owner_cyc && (outstanding == '0)) begin
          state_nx      = rel_state;
          grant_nx      = rel_grant;
          last_owner_nx = owner;
        end else if (!owner_cyc || fairness_hold) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_nx == '0) begin
          state_nx      = rel_state;
          grant_nx      = rel_grant;
          last_owner_nx = owner;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
      end
    endcase

    // burst count restarts whenever ownership changes
    if (grant_nx != o_grant)
      beats_nx = '0;
    else if (accept && (beats != BCW'(MAX_BURST)))
      beats_nx = beats + BCW'(1);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state          <= IDLE;
      o_grant        <= 2'b00;
      outstanding    <= '0;
      beats          <= '0;
      last_owner     <= 1'b1;
      o_protocol_err <= 1'b0;
    end else begin
      state          <= state_nx;
      o_grant        <= grant_nx;
      outstanding    <= outstanding_nx;
      beats          <= beats_nx;
      last_owner     <= last_owner_nx;
      o_protocol_err <= err_nx;
    end
  end

endmodule
